// File: rtl/counter_sched_ctrl_if.sv
// Wishbone slave bundle (MI A port) for counter_sched_ctrl.
// The master modport is the bus side and the slave modport is the controller side.
interface counter_sched_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/counter_sched_ctrl.sv
// Wishbone-mapped sequencer for an external counter: prescaled count ticks, LA/WB load
// arbitration, compare-match detection and a level IRQ.
module counter_sched_ctrl #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  counter_sched_ctrl_if.slave  wbs,
  input  logic                 la_load_i,
  input  logic [BITS-1:0]      la_value_i,
  input  logic [BITS-1:0]      cnt_val_i,
  output logic                 cnt_en_o,
  output logic                 cnt_load_o,
  output logic [BITS-1:0]      cnt_load_val_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [2:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_psc;
  logic [BITS-1:0]       r_load;
  logic [BITS-1:0]       r_cmp;
  logic [BITS-1:0]       r_la_val;
  logic                  r_match;
  logic                  r_ack;
  logic [31:0]           r_rdata;
  logic                  r_tick_d1;
  logic                  r_la_d;
  logic                  r_la_pend;
  logic                  r_wb_pend;

  logic                  w_acc;
  logic                  w_wr;
  logic [2:0]            w_adr;
  logic                  w_wr_ctrl;
  logic                  w_wr_psc;
  logic                  w_wr_load;
  logic                  w_wr_cmp;
  logic                  w_wr_stat;
  logic                  w_w1c;
  logic [2:0]            w_ctrl_nx;
  logic                  w_la_rise;
  logic                  w_load;
  logic                  w_tick;
  logic                  w_match_evt;
  logic                  w_auto_clr;
  logic [31:0]           w_rmux;
  logic                  w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_unused  = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};
  assign w_acc     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
  assign w_wr      = w_acc & wbs.wbs_we_i;
  assign w_adr     = wbs.wbs_adr_i[4:2];
  assign w_wr_ctrl = w_wr && (w_adr == 3'd0);
  assign w_wr_psc  = w_wr && (w_adr == 3'd1);
  assign w_wr_load = w_wr && (w_adr == 3'd2);
  assign w_wr_cmp  = w_wr && (w_adr == 3'd3);
  assign w_wr_stat = w_wr && (w_adr == 3'd4);
  assign w_w1c     = w_wr_stat & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
  assign w_ctrl_nx = 3'(f_merge(32'(r_ctrl), wbs.wbs_dat_i, wbs.wbs_sel_i));

  // LA wins a collision; a losing WB request simply stays latched one more cycle.
  assign w_la_rise   = la_load_i & ~r_la_d;
  assign w_load      = r_la_pend | r_wb_pend;
  assign w_tick      = (r_state == ST_RUN) && !w_load && (r_psc == r_prescale);
  assign w_match_evt = r_tick_d1 && (cnt_val_i == r_cmp);

  assign cnt_en_o       = w_tick;
  assign cnt_load_o     = w_load;
  assign cnt_load_val_o = r_la_pend ? r_la_val : (r_wb_pend ? r_load : '0);
  assign irq_o          = r_match & r_ctrl[2];
  assign wbs.wbs_ack_o  = r_ack;
  assign wbs.wbs_dat_o  = r_rdata;

  always_comb begin
    w_state_nx = r_state;
    w_auto_clr = 1'b0;
    unique case (r_state)
      ST_IDLE: if (r_ctrl[0]) w_state_nx = ST_RUN;
      ST_RUN: begin
        if (!r_ctrl[0]) begin
          w_state_nx = ST_IDLE;
        end else if (w_match_evt && r_ctrl[1]) begin
          w_state_nx = ST_DONE;
          w_auto_clr = 1'b1;
        end
      end
      ST_DONE: if (w_wr_ctrl) w_state_nx = w_ctrl_nx[0] ? ST_RUN : ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rmux = '0;
    case (w_adr)
      3'd0:    w_rmux = 32'(r_ctrl);
      3'd1:    w_rmux = 32'(r_prescale);
      3'd2:    w_rmux = 32'(r_load);
      3'd3:    w_rmux = 32'(r_cmp);
      3'd4:    w_rmux = {29'b0, r_state == ST_DONE, r_state == ST_RUN, r_match};
      3'd5:    w_rmux = 32'(cnt_val_i);
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_load     <= '0;
      r_cmp      <= '0;
      r_match    <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc && !wbs.wbs_we_i) ? w_rmux : '0;
      if (w_wr_ctrl) r_ctrl <= w_ctrl_nx;
      if (w_auto_clr) r_ctrl[0] <= 1'b0;
      if (w_wr_psc)
        r_prescale <= PRESCALE_W'(f_merge(32'(r_prescale), wbs.wbs_dat_i, wbs.wbs_sel_i));
      if (w_wr_load)
        r_load <= BITS'(f_merge(32'(r_load), wbs.wbs_dat_i, wbs.wbs_sel_i));
      if (w_wr_cmp)
        r_cmp <= BITS'(f_merge(32'(r_cmp), wbs.wbs_dat_i, wbs.wbs_sel_i));
      // A match landing on the same edge as a W1C keeps MATCH set.
      if (w_match_evt) r_match <= 1'b1;
      else if (w_w1c)  r_match <= 1'b0;
    end
  end

  // psc >= PRESCALE also covers a PRESCALE lowered mid-run: wrap to 0 with no tick.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_psc     <= '0;
      r_tick_d1 <= 1'b0;
    end else begin
      r_tick_d1 <= w_tick;
      if ((r_state != ST_RUN) || w_load || (r_psc >= r_prescale)) r_psc <= '0;
      else r_psc <= r_psc + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_la_d    <= 1'b0;
      r_la_pend <= 1'b0;
      r_la_val  <= '0;
      r_wb_pend <= 1'b0;
    end else begin
      r_la_d    <= la_load_i;
      r_la_pend <= w_la_rise;
      if (w_la_rise) r_la_val <= la_value_i;
      if (w_wr_load) r_wb_pend <= 1'b1;
      else if (r_wb_pend && !r_la_pend) r_wb_pend <= 1'b0;
    end
  end

endmodule
